ulpi_rx_decoder: RTL
====================

Name: ulpi_rx_decoder

Overview:
- Sits directly downstream of the ULPI-to-AXIS bridge and consumes its rx stream: tdata = bus byte, tuser = {rxactive, phydata}.
- Splits the stream into three outputs:
  - RXCMD status: line state, VBUS, events, ID, alt_int.
  - Register-read return data.
  - A framed USB packet byte stream with tlast and an error flag.
- One-byte hold register delays packet data so tlast lands on the final byte.

Parameters:
STAT_WIDTH, 16, width of the packet/error counters (used only with ULPI_RX_STATS_EN).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_tvalid  in  1  byte from ULPI bridge valid (dir high, not turnaround)
rx_tdata  in  8  bus byte
rx_tuser  in  2  [1]=rxactive, [0]=phydata (1: RXCMD/register data, 0: USB data)
rx_tready  out  1  always 1 (bridge asserts stp on 0; receive must never be aborted)
reg_rd_pending  in  1  register read issued; next phydata byte is register data
reg_rdata  out  8  captured register read data
reg_rvalid  out  1  one-cycle pulse with reg_rdata
pkt_tdata  out  8  USB packet byte
pkt_tvalid  out  1  packet byte valid
pkt_tready  in  1  consumer accepts byte
pkt_tlast  out  1  last byte of packet
pkt_tuser  out  1  on tlast beat: 1 = packet bad (RxError or overflow)
linestate  out  2  RXCMD[1:0]
vbus_state  out  2  RXCMD[3:2]
rx_active  out  1  RxEvent decode: 01 or 11
rx_error  out  1  RxEvent == 11
host_disc  out  1  RxEvent == 10
id_gnd  out  1  RXCMD[6]
alt_int  out  1  RXCMD[7]
rxcmd_upd  out  1  one-cycle pulse on each RXCMD captured

Behaviour:
- Reset values:
  - All outputs 0, except rx_tready = 1 at all times.
  - Status registers 0.
  - FSM in IDLE; hold and output registers empty.
- Beat classification, on rx_tvalid only:
  - phydata=1 and reg_rd_pending=1: register data. reg_rdata <= tdata; reg_rvalid pulses next cycle. Not decoded as RXCMD.
  - phydata=1 otherwise: RXCMD. All status outputs update next cycle; rxcmd_upd pulses.
  - phydata=0: USB data byte.
- FSM has two states, IDLE and RECV.
  - IDLE -> RECV: valid beat with rxactive=1.
  - RECV -> IDLE (end of packet):
    - valid RXCMD beat with rxactive=0, or
    - rx_tvalid=0 in any cycle (dir dropped; the bridge emits no turnaround gap while dir stays high).
- Data path:
  - Each USB data byte in RECV goes into the hold register.
  - If the hold register is already full, its previous byte moves to the output register with tlast=0.
  - At end of packet, a full hold register moves to output with tlast=1 and pkt_tuser=bad.
  - Zero-byte packet: nothing emitted; bad flag cleared.
- Bad flag:
  - Set by an RXCMD with RxEvent=11 during RECV, or by overflow.
  - Cleared on entry to RECV.
- Output register is an AXIS master:
  - Holds its value while pkt_tvalid & ~pkt_tready.
  - Byte latency from data beat to pkt_tvalid is 2 cycles for non-last bytes.
  - Last byte appears 1 cycle after end detection.
- Overflow:
  - Occurs when a byte must move into an occupied, unaccepted output register.
  - The incoming moved byte is dropped and bad is set.
  - If the overflowing move is the tlast byte, it overwrites the stalled byte and carries tlast with pkt_tuser=1, so framing is never lost.
- Simultaneous events:
  - Same-cycle end and new rxactive start cannot occur: at least one RXCMD or gap separates them.
  - Data beat and output accept in the same cycle move without overflow.
- rst mid-packet:
  - Discards the hold and output registers; no tlast is emitted.
  - FSM returns to IDLE.

Optional Feature:
- Macro: ULPI_RX_STATS_EN.
- When defined, adds outputs stat_pkts[STAT_WIDTH-1:0] and stat_errs[STAT_WIDTH-1:0].
  - stat_pkts increments on each accepted tlast beat.
  - stat_errs increments when that beat also has pkt_tuser=1.
  - Counters saturate at all-ones; reset to 0.
- When undefined, the ports and logic are absent; the block is otherwise unchanged.

Test Plan:
- RXCMD 8'h4D with phydata=1, rxactive=0 -> next cycle: linestate=01, vbus_state=11, rx_active=0, id_gnd=1, alt_int=0; rxcmd_upd pulses once.
- reg_rd_pending=1, phydata beat 8'hA5 -> reg_rvalid one cycle with reg_rdata=A5; status outputs unchanged; no rxcmd_upd.
- Start beat rxactive=1, data C3 11 22, then rx_tvalid=0, pkt_tready=1 -> pkt bytes C3, 11, 22; tlast only on 22; pkt_tuser=0.
- Packet 2D 00 10 with RXCMD 8'h30 (RxError) mid-packet, then RXCMD rxactive=0 -> last beat 10 has tlast=1, pkt_tuser=1; rx_error=1 after the RXCMD.
- pkt_tready=0 through a 4-byte packet 01 02 03 04 -> first byte 01 held stable; the final output beat is 04 with tlast=1, pkt_tuser=1.
- rst asserted after 2 data bytes of a packet -> pkt_tvalid=0 next cycle; a following 1-byte packet 5A emits 5A with tlast=1, pkt_tuser=0.
- With ULPI_RX_STATS_EN: the two preceding packets, one bad -> stat_pkts=2, stat_errs=1.

Source files
------------

// File: rtl/ulpi_rx_decoder.sv
// ulpi_rx_decoder
//   Consumes the receive stream of the ULPI-to-AXIS bridge and splits it into
//   three outputs:
//   - RXCMD status (line state, VBUS, RxEvent decode, ID, alt_int).
//   - Register-read return data.
//   - A framed USB packet byte stream. A one-byte hold register delays the
//     packet bytes so that tlast lands on the final byte.
//
// Optional feature: define ULPI_RX_STATS_EN to add saturating packet and
//   bad-packet counters (stat_pkts / stat_errs, STAT_WIDTH bits wide).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rx_tvalid         bridge byte valid
//   rx_tdata          bus byte
//   rx_tuser          [1] rxactive, [0] phydata (1: RXCMD/register data)
//   rx_tready         tied high; a receive must never be aborted
//   reg_rd_pending    next phydata byte is register-read data
//   reg_rdata         captured register data
//   reg_rvalid        one-cycle pulse with reg_rdata
//   pkt_tdata         packet stream: data byte
//   pkt_tvalid        packet stream: byte valid
//   pkt_tready        packet stream: consumer ready
//   pkt_tlast         packet stream: last byte of packet
//   pkt_tuser         packet stream: on the tlast beat, 1 = packet bad
//   linestate         RXCMD[1:0]
//   vbus_state        RXCMD[3:2]
//   rx_active         RxEvent is 01 or 11
//   rx_error          RxEvent is 11
//   host_disc         RxEvent is 10
//   id_gnd            RXCMD[6]
//   alt_int           RXCMD[7]
//   rxcmd_upd         one-cycle pulse per captured RXCMD
//   stat_pkts         (ULPI_RX_STATS_EN) accepted tlast beats
//   stat_errs         (ULPI_RX_STATS_EN) accepted tlast beats with pkt_tuser
module ulpi_rx_decoder #(
  parameter int STAT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_tvalid,
  input  logic [7:0] rx_tdata,
  input  logic [1:0] rx_tuser,
  output logic       rx_tready,
  input  logic       reg_rd_pending,
  output logic [7:0] reg_rdata,
  output logic       reg_rvalid,
  output logic [7:0] pkt_tdata,
  output logic       pkt_tvalid,
  input  logic       pkt_tready,
  output logic       pkt_tlast,
  output logic       pkt_tuser,
  output logic [1:0] linestate,
  output logic [1:0] vbus_state,
  output logic       rx_active,
  output logic       rx_error,
  output logic       host_disc,
  output logic       id_gnd,
  output logic       alt_int,
  output logic       rxcmd_upd
`ifdef ULPI_RX_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_pkts,
  output logic [STAT_WIDTH-1:0] stat_errs
`endif
);

  if (STAT_WIDTH < 1) begin : g_stat_width_check
    $error("STAT_WIDTH must be at least 1");
  end

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state, state_next;

  logic       rxactive_in;
  logic [1:0] rx_event_in;
  logic       is_reg, is_cmd, is_data;
  logic       pkt_start, pkt_end;
  logic       capture, move, out_free, overflow, err_evt, bad_now;
  logic [7:0] hold_data;
  logic       hold_full;
  logic       bad;

  assign rx_tready   = 1'b1;
  assign rxactive_in = rx_tuser[1];
  assign rx_event_in = rx_tdata[5:4];

  // Beat classification; a pending register read claims the phydata byte.
  assign is_reg  = rx_tvalid &  rx_tuser[0] &  reg_rd_pending;
  assign is_cmd  = rx_tvalid &  rx_tuser[0] & ~reg_rd_pending;
  assign is_data = rx_tvalid & ~rx_tuser[0];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pkt_start  = 1'b0;
    pkt_end    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_tvalid && rxactive_in) begin
          state_next = RECV;
          pkt_start  = 1'b1;
        end
      end
      RECV: begin
        // dir dropping shows up as a gap in rx_tvalid; the bridge never
        // inserts a gap while dir stays high.
        if (!rx_tvalid || (is_cmd && !rxactive_in)) begin
          state_next = IDLE;
          pkt_end    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture  = is_data & ((state == RECV) | pkt_start);
  assign move     = hold_full & (capture | pkt_end);
  assign out_free = ~pkt_tvalid | pkt_tready;
  assign overflow = move & ~out_free;
  assign err_evt  = is_cmd & (rx_event_in == 2'b11) & (state == RECV);
  // Includes this cycle's events so a closing RxError or overflow is
  // reflected on the tlast beat it coincides with.
  assign bad_now  = bad | err_evt | overflow;

  // NOTE: the hold byte is only read while hold_full is set, so it carries
  // no reset; hold_full alone marks it empty after rst.
  always_ff @(posedge clk) begin
    if (capture) hold_data <= rx_tdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      bad        <= 1'b0;
      pkt_tdata  <= '0;
      pkt_tvalid <= 1'b0;
      pkt_tlast  <= 1'b0;
      pkt_tuser  <= 1'b0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
      rxcmd_upd  <= 1'b0;
      linestate  <= '0;
      vbus_state <= '0;
      rx_active  <= 1'b0;
      rx_error   <= 1'b0;
      host_disc  <= 1'b0;
      id_gnd     <= 1'b0;
      alt_int    <= 1'b0;
    end else begin
      state      <= state_next;
      reg_rvalid <= is_reg;
      rxcmd_upd  <= is_cmd;
      if (is_reg) reg_rdata <= rx_tdata;

      if (is_cmd) begin
        linestate  <= rx_tdata[1:0];
        vbus_state <= rx_tdata[3:2];
        rx_active  <= rx_event_in[0];
        rx_error   <= (rx_event_in == 2'b11);
        host_disc  <= (rx_event_in == 2'b10);
        id_gnd     <= rx_tdata[6];
        alt_int    <= rx_tdata[7];
      end

      if (pkt_tvalid && pkt_tready) begin
        pkt_tvalid <= 1'b0;
        pkt_tlast  <= 1'b0;
        pkt_tuser  <= 1'b0;
      end

      if (move) begin
        if (out_free) begin
          pkt_tdata  <= hold_data;
          pkt_tvalid <= 1'b1;
          pkt_tlast  <= pkt_end;
          pkt_tuser  <= pkt_end & bad_now;
        end else if (pkt_end) begin
          // A stalled output would otherwise swallow the frame end: the
          // last byte overwrites it and carries the bad marking.
          pkt_tdata <= hold_data;
          pkt_tlast <= 1'b1;
          pkt_tuser <= 1'b1;
        end
      end

      if (capture)      hold_full <= 1'b1;
      else if (pkt_end) hold_full <= 1'b0;

      if (pkt_start || pkt_end)   bad <= 1'b0;
      else if (err_evt || overflow) bad <= 1'b1;
    end
  end

`ifdef ULPI_RX_STATS_EN
  logic last_accept;
  assign last_accept = pkt_tvalid & pkt_tready & pkt_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts <= '0;
      stat_errs <= '0;
    end else if (last_accept) begin
      if (stat_pkts != '1) stat_pkts <= stat_pkts + 1'b1;
      if (pkt_tuser && (stat_errs != '1)) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif

endmodule
